multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
Parametrised N-channel debouncer for raw push-button and switch inputs feeding the stopwatch control logic. Each channel has a synchroniser chain and a saturating stability counter. The debounced level toggles only after the synchronised input has differed from it for a programmable number of consecutive sample ticks. Each channel also emits single-cycle rise/fall pulses, so downstream FSMs need no edge detector of their own.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
STABLE_CYCLES, 16, consecutive qualifying sample ticks required to accept a new level (>=1)
INIT_VALUE, 0, 1-bit level loaded into synchronisers and out[] on reset (applied to all channels)
REPEAT_DELAY, 500, sample ticks of continuous high before the first auto-repeat pulse (repeat feature only, >=1)
REPEAT_PERIOD, 100, sample ticks between subsequent auto-repeat pulses (repeat feature only, >=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sample_en  input  1  sample tick qualifier; tie high to count every clock
in  input  CHANNELS  raw asynchronous inputs, one bit per channel
out  output  CHANNELS  debounced, registered levels
rise  output  CHANNELS  one-cycle pulse when out[i] goes 0->1
fall  output  CHANNELS  one-cycle pulse when out[i] goes 1->0
rpt  output  CHANNELS  one-cycle auto-repeat pulse; constant 0 without the optional feature

Behaviour:
- Reset (rst=1 at a rising edge): all synchroniser stages and out[] <= INIT_VALUE; counters <= 0; rise, fall and rpt <= 0. Any count in progress is abandoned. rst takes priority over all other inputs.
- Synchroniser: in[i] is shifted through SYNC_STAGES flops. y[i] is the last stage. Only y[i] is used by downstream logic.
- Counter per channel, width clog2(STABLE_CYCLES) bits minimum. Evaluated each edge:
  - y[i]==out[i]: cnt <= 0, regardless of sample_en.
  - y[i]!=out[i], sample_en=0: cnt holds.
  - y[i]!=out[i], sample_en=1, cnt<STABLE_CYCLES-1: cnt <= cnt+1.
  - y[i]!=out[i], sample_en=1, cnt==STABLE_CYCLES-1: out[i] <= y[i]; cnt <= 0; rise[i] or fall[i] <= 1 for exactly this cycle.
- Any bounce back to the out[i] level clears cnt. The count restarts from zero on the next difference.
- Latency with sample_en=1: out[i] changes on the (SYNC_STAGES+STABLE_CYCLES)th rising edge after in[i] changes. The capture edge counts as edge 1. Defaults give 18 clocks.
- STABLE_CYCLES=1: out[i] takes y[i] on every sample_en edge where they differ.
- rise, fall and rpt are registered, and are 0 in every cycle in which they are not explicitly pulsed. rise[i] and fall[i] are never high together.
- Channels are fully independent. Simultaneous transitions on several channels produce their pulses in the same cycle.
- Counters saturate by construction and never wrap.

Optional Feature:
Macro MULTI_DEBOUNCER_REPEAT_EN.
- Defined: each channel has an extra repeat counter. It clears whenever out[i]=0, on a rise[i] cycle, and on reset.
  - While out[i]=1 it increments on each sample_en edge.
  - rpt[i] pulses one cycle when the counter reaches REPEAT_DELAY sample ticks after the rise.
  - It then pulses every REPEAT_PERIOD sample ticks until out[i] falls.
  - A fall stops repeats immediately; no rpt pulse occurs in the fall cycle.
- Not defined: no repeat counters are built and rpt is tied to 0.

Test Plan:
1. Reset. CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, INIT_VALUE=0, sample_en=1. Hold rst=1 for 3 clocks with in=2'b11. Required: out=00, rise=fall=rpt=00 throughout. After release, out=11 on edge 6, and rise=11 for exactly one cycle.
2. Clean press. in[0] goes 0->1 and holds. Required: out[0]=1 after edge 6, rise[0]=1 for that one cycle only. fall=00, and out[1] is unchanged.
3. Bounce. in[0] toggles every 2 clocks for 20 clocks, then holds 1. Required: out[0] stays 0 during the bounce, rises 6 edges after the last transition, and exactly one rise[0] pulse occurs overall.
4. Throttled ticks. sample_en high 1 cycle in 4; in[0] goes 0->1. Required: out[0] changes on the 4th sample_en edge at which y[0]!=out[0], not before. The count holds (does not clear) on sample_en=0 cycles.
5. Simultaneous events and mid-count reset.
   - Start from out=01, then in goes 01->10. Required: rise[1] and fall[0] pulse in the same cycle.
   - Separately, assert rst while cnt=2 mid-count. Required: out stays INIT_VALUE, and after release a full 6 edges are needed to change.
6. Repeat (MULTI_DEBOUNCER_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=3, sample_en=1). Hold in[0]=1. Required: rpt[0] pulses 5, 8 and 11 edges after rise[0]. Releasing in[0] gives a fall[0] pulse, no further rpt[0] pulses, and no rpt[0] in the fall cycle. Without the macro, rpt=00 always.

Source files
------------

// File: rtl/multi_debouncer.sv
// N-channel push-button/switch debouncer: synchroniser, saturating stability counter, and registered rise/fall pulses.
// Optional auto-repeat pulses on held inputs are enabled by defining MULTI_DEBOUNCER_REPEAT_EN.
module multi_debouncer #(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic INIT_VALUE    = 1'b0,
    parameter int   REPEAT_DELAY  = 500,
    parameter int   REPEAT_PERIOD = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt
);

    localparam int              CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CHANNELS-1:0]    y;
    logic [CHANNELS-1:0]    commit;
    logic [CHANNELS-1:0]    out_next;

    // commit marks the edge on which a channel accepts its new level.
    always_comb begin
        y        = '0;
        commit   = '0;
        out_next = out;
        for (int i = 0; i < CHANNELS; i++) begin
            y[i]        = sync_q[i][SYNC_STAGES-1];
            commit[i]   = sample_en && (y[i] != out[i]) && (cnt_q[i] == CNT_LAST);
            out_next[i] = commit[i] ? y[i] : out[i];
        end
    end

    // NOTE: all state uses non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {SYNC_STAGES{INIT_VALUE}};
                cnt_q[i]  <= '0;
            end
            out  <= {CHANNELS{INIT_VALUE}};
            rise <= '0;
            fall <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in[i]};
                if ((y[i] == out[i]) || commit[i])
                    cnt_q[i] <= '0;
                else if (sample_en)
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
            out  <= out_next;
            rise <= out_next & ~out;
            fall <= ~out_next & out;
        end
    end

`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W       = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_HIT   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] PERIOD_HIT  = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0]    rcnt_q [CHANNELS];
    logic [CHANNELS-1:0] repeating_q;

    // The first pulse waits REPEAT_DELAY ticks, later ones REPEAT_PERIOD; a fall edge clears before any pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) rcnt_q[i] <= '0;
            repeating_q <= '0;
            rpt         <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!out_next[i] || (commit[i] && y[i])) begin
                    rcnt_q[i]      <= '0;
                    repeating_q[i] <= 1'b0;
                    rpt[i]         <= 1'b0;
                end else if (sample_en) begin
                    if ((rcnt_q[i] + RPT_W'(1)) == (repeating_q[i] ? PERIOD_HIT : DELAY_HIT)) begin
                        rcnt_q[i]      <= '0;
                        repeating_q[i] <= 1'b1;
                        rpt[i]         <= 1'b1;
                    end else begin
                        rcnt_q[i] <= rcnt_q[i] + RPT_W'(1);
                        rpt[i]    <= 1'b0;
                    end
                end else begin
                    rpt[i] <= 1'b0;
                end
            end
        end
    end
`else
    // Repeat timing parameters only matter when the feature is built; rpt is a constant zero here.
    localparam logic RPT_TIE = (REPEAT_DELAY > 0 && REPEAT_PERIOD > 0) ? 1'b0 : 1'b0;
    assign rpt = {CHANNELS{RPT_TIE}};
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer (2 channels, 2 sync stages, 4 stable ticks, repeat 5/3).
// Repeat expectations apply only when MULTI_DEBOUNCER_REPEAT_EN is defined; otherwise rpt must stay 0.
module tb_multi_debouncer;

    localparam int CH     = 2;
    localparam int DELAY  = 5;
    localparam int PERIOD = 3;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b1;
    logic [CH-1:0] in = '0;
    logic [CH-1:0] out, rise, fall, rpt;

    multi_debouncer #(
        .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT_VALUE(1'b0),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .in(in),
        .out(out), .rise(rise), .fall(fall), .rpt(rpt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic [CH-1:0] in;
        logic [CH-1:0] out;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] rpt;
    } vec_t;

    typedef struct {
        logic [CH-1:0] out;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] rpt;
        string         tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rise0_count = 0;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // One clock: drive on the falling edge, queue expectations, compare 1 ns after the rising edge.
    task automatic step(input logic r, input logic e, input logic [CH-1:0] i, input exp_t x);
        exp_t got;
        @(negedge clk);
        rst       = r;
        sample_en = e;
        in        = i;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".out"},  out,  got.out);
        check({got.tag, ".rise"}, rise, got.rise);
        check({got.tag, ".fall"}, fall, got.fall);
        check({got.tag, ".rpt"},  rpt,  got.rpt);
        rise0_count += int'(rise[0]);
    endtask

    function automatic exp_t mk(input logic [CH-1:0] o, input logic [CH-1:0] r, input logic [CH-1:0] f,
                                input logic [CH-1:0] p, input string tag);
        exp_t x;
        x.out  = o;
        x.rise = r;
        x.fall = f;
        x.rpt  = REP_EN ? p : '0;
        x.tag  = tag;
        return x;
    endfunction

    // Repeat pulse expected k ticks after the rise edge.
    function automatic logic rep_hit(input int k);
        return (k >= DELAY) && (((k - DELAY) % PERIOD) == 0);
    endfunction

    task automatic add(input logic r, input logic [CH-1:0] i, input logic [CH-1:0] o, input logic [CH-1:0] rs,
                       input logic [CH-1:0] f, input logic [CH-1:0] p);
        vec_t v;
        v.rst = r; v.en = 1'b1; v.in = i; v.out = o; v.rise = rs; v.fall = f; v.rpt = p;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with inputs high, release, then clean fall/rise and simultaneous opposite transitions.
        for (int k = 0; k < 3; k++) add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++) add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11);
        add(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
        add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10);
        add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10);
        add(0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
        add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);

        for (int k = 0; k < tbl.size(); k++)
            step(tbl[k].rst, tbl[k].en, tbl[k].in,
                 mk(tbl[k].out, tbl[k].rise, tbl[k].fall, tbl[k].rpt, $sformatf("vec%0d", k)));

        // Bounce on channel 0, then a long hold (auto-repeat), then release.
        for (int k = 0; k < 2; k++) step(1, 1, 2'b00, mk(2'b00, 2'b00, 2'b00, 2'b00, "bounce_rst"));
        rise0_count = 0;
        for (int k = 0; k < 20; k++)
            step(0, 1, {1'b0, ((k / 2) % 2) == 0}, mk(2'b00, 2'b00, 2'b00, 2'b00, $sformatf("bounce%0d", k)));
        for (int h = 1; h <= 18; h++)
            step(0, 1, 2'b01, mk({1'b0, h >= 6}, {1'b0, h == 6}, 2'b00,
                                 {1'b0, (h >= 6) && rep_hit(h - 6)}, $sformatf("hold%0d", h)));
        for (int r = 1; r <= 10; r++)
            step(0, 1, 2'b00, mk({1'b0, r < 6}, 2'b00, {1'b0, r == 6},
                                 {1'b0, (r < 6) && rep_hit(12 + r)}, $sformatf("release%0d", r)));
        n_checks++;
        if (rise0_count != 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d, expected 1", rise0_count);
        end

        // Throttled sample ticks: one enable in four; the count must hold across idle cycles.
        for (int k = 0; k < 2; k++) step(1, 1, 2'b00, mk(2'b00, 2'b00, 2'b00, 2'b00, "thr_rst"));
        for (int c = 1; c <= 20; c++)
            step(0, (c % 4) == 3, 2'b01, mk({1'b0, c >= 15}, {1'b0, c == 15}, 2'b00, 2'b00,
                                            $sformatf("throttle%0d", c)));

        // Reset in the middle of a count: a full six edges are needed afterwards.
        for (int k = 0; k < 2; k++) step(1, 1, 2'b00, mk(2'b00, 2'b00, 2'b00, 2'b00, "mid_rst0"));
        for (int c = 1; c <= 12; c++)
            step(c == 5, 1, 2'b01, mk({1'b0, c >= 11}, {1'b0, c == 11}, 2'b00, 2'b00,
                                      $sformatf("midcount%0d", c)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
